// File: rtl/simple_pkg.sv
// Shared types and defaults for the core/loader memory arbiter.
package simple_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} arb_state_t;
    typedef enum logic {CORE = 1'b0, LOADER = 1'b1} owner_t;

    // One entry of the read-return tag pipeline
    typedef struct packed {
        logic   vld;
        owner_t owner;
    } tag_t;
endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin grant; bit 0 = core, bit 1 = loader.
module rr_grant2
    import simple_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last,
    input  logic       i_lock,
    output logic [1:0] o_gnt
);
    always_comb begin
        o_gnt = '0;
        if (i_lock) begin
            o_gnt[1] = i_req[1];
        end else if (&i_req) begin
            // Tie goes to whoever was not served last
            o_gnt = (i_last == LOADER) ? 2'b01 : 2'b10;
        end else begin
            o_gnt = i_req;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the core and the loader/debug port,
// with round-robin fairness and a loader lock mode that times out when idle.
module mem_arbiter
    import simple_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic [DW-1:0] core_rdata,
    output logic          core_rvalid,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          ld_lock,
    output logic          ld_gnt,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_rvalid,
    output logic          mem_e,
    output logic          mem_w,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_in,
    input  logic [DW-1:0] mem_out,
    output logic          locked,
    output logic          lock_timeout
);
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    arb_state_t    r_state, w_state_nxt;
    owner_t        r_last;
    logic [7:0]    r_idle_cnt, w_idle_nxt;
    logic          w_to_set, r_lock_to;
    logic [1:0]    w_gnt;
    logic          w_acc_core, w_acc_ld, w_acc, w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    tag_t [1:0]    r_tag;
    logic          r_mem_e, r_mem_w;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_in;
    logic [DW-1:0] r_core_rdata, r_ld_rdata;
    logic          w_core_rv, w_ld_rv;

    rr_grant2 u_rr (
        .i_req  ({ld_req, core_req}),
        .i_last (r_last),
        .i_lock (r_state == LOCK),
        .o_gnt  (w_gnt)
    );

    // Grants are suppressed while reset is held
    assign core_gnt   = w_gnt[0] & rst;
    assign ld_gnt     = w_gnt[1] & rst;
    assign w_acc_core = core_gnt;
    assign w_acc_ld   = ld_gnt;
    assign w_acc      = w_acc_core | w_acc_ld;
    assign w_we       = w_acc_ld ? ld_we    : core_we;
    assign w_addr     = w_acc_ld ? ld_addr  : core_addr;
    assign w_wdata    = w_acc_ld ? ld_wdata : core_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = r_idle_cnt;
        w_to_set    = 1'b0;
        case (r_state)
            ARB: begin
                w_idle_nxt = '0;
                if (w_acc_ld && ld_lock) w_state_nxt = LOCK;
            end
            LOCK: begin
                if (ld_req) begin
                    w_idle_nxt = '0;
                    if (w_acc_ld && !ld_lock) w_state_nxt = ARB;
                end else if (r_idle_cnt + 8'd1 == TO_CNT) begin
                    w_state_nxt = ARB;
                    w_idle_nxt  = '0;
                    w_to_set    = 1'b1;
                end else begin
                    w_idle_nxt = r_idle_cnt + 8'd1;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ARB;
            r_idle_cnt <= '0;
            r_lock_to  <= 1'b0;
            r_last     <= LOADER;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_nxt;
            if (w_to_set)        r_lock_to <= 1'b1;
            if (w_acc_core)      r_last    <= CORE;
            else if (w_acc_ld)   r_last    <= LOADER;
        end
    end

    // Command register and read tag pipeline; address/data hold when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_e    <= 1'b0;
            r_mem_w    <= 1'b0;
            r_mem_addr <= '0;
            r_mem_in   <= '0;
            r_tag      <= '0;
        end else begin
            r_mem_e <= w_acc;
            r_mem_w <= w_acc & w_we;
            if (w_acc) begin
                r_mem_addr <= w_addr;
                r_mem_in   <= w_wdata;
            end
            r_tag[0].vld   <= w_acc & ~w_we;
            r_tag[0].owner <= w_acc_ld ? LOADER : CORE;
            r_tag[1]       <= r_tag[0];
        end
    end

    assign w_core_rv = r_tag[1].vld & (r_tag[1].owner == CORE);
    assign w_ld_rv   = r_tag[1].vld & (r_tag[1].owner == LOADER);

    // Read data passes straight from memory in its return cycle, else holds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_core_rdata <= '0;
            r_ld_rdata   <= '0;
        end else begin
            r_core_rdata <= core_rdata;
            r_ld_rdata   <= ld_rdata;
        end
    end

    assign core_rdata   = w_core_rv ? mem_out : r_core_rdata;
    assign ld_rdata     = w_ld_rv   ? mem_out : r_ld_rdata;
    assign core_rvalid  = w_core_rv;
    assign ld_rvalid    = w_ld_rv;
    assign mem_e        = r_mem_e;
    assign mem_w        = r_mem_w;
    assign mem_address  = r_mem_addr;
    assign mem_in       = r_mem_in;
    assign locked       = (r_state == LOCK);
    assign lock_timeout = r_lock_to;
endmodule
